// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencing and instruction-memory request control.
// Handles wait states, redirects, traps, halt/resume in fixed priority.
module fetch_ctrl #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PC,
   output logic [31:0] PC_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   output logic        instr_valid,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   input  logic        trap,
   input  logic        halt,
   input  logic        resume,
   output logic [31:0] epc,
   output logic        misaligned_fault,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      S_BOOT  = 2'b00,
      S_FETCH = 2'b01,
      S_HALT  = 2'b10
   } state_e;

   state_e      state_q, state_d;
   logic        pend_valid_q, pend_valid_d;
   logic        pend_trap_q, pend_trap_d;
   logic        halt_pend_q, halt_pend_d;
   logic [31:0] pend_target_q, pend_target_d;
   logic [31:0] epc_q, epc_d;

   logic        fetching;
   logic        mis;
   logic        ev_trap;
   logic        ev_redir;
   logic        ev_any;
   logic [31:0] ev_target;

   assign fetching  = (state_q == S_FETCH);
   assign mis       = redirect && (redirect_target[1:0] != 2'b00);
   assign ev_trap   = fetching && (trap || mis);
   assign ev_redir  = fetching && redirect && !trap && !mis;
   assign ev_any    = ev_trap || ev_redir;
   assign ev_target = ev_trap ? TRAP_VECTOR : redirect_target;

   assign imem_req         = fetching;
   assign imem_addr        = PC;
   assign epc              = epc_q;
   assign state            = state_q;
   assign misaligned_fault = fetching && mis && !trap;

   always_comb begin
      state_d       = state_q;
      pend_valid_d  = pend_valid_q;
      pend_trap_d   = pend_trap_q;
      pend_target_d = pend_target_q;
      halt_pend_d   = halt_pend_q;
      epc_d         = epc_q;
      PC_next       = PC;
      instr_valid   = 1'b0;
      unique case (state_q)
         S_BOOT: begin
            PC_next = RESET_VECTOR;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (ev_trap)
               epc_d = PC;
            if (ev_any) begin
               if (imem_ready) begin
                  PC_next      = ev_target;
                  pend_valid_d = 1'b0;
                  pend_trap_d  = 1'b0;
               end else if (!(pend_valid_q && pend_trap_q && ev_redir)) begin
                  // a buffered trap outranks any later plain redirect
                  pend_valid_d  = 1'b1;
                  pend_trap_d   = ev_trap;
                  pend_target_d = ev_target;
               end
            end else if (imem_ready) begin
               if (pend_valid_q) begin
                  PC_next      = pend_target_q;
                  pend_valid_d = 1'b0;
                  pend_trap_d  = 1'b0;
                  if (halt)
                     halt_pend_d = 1'b1;
               end else if (halt_pend_q || halt) begin
                  halt_pend_d = 1'b0;
                  state_d     = S_HALT;
               end else if (!stall) begin
                  instr_valid = 1'b1;
                  PC_next     = PC + 32'd4;
               end
            end else if (halt) begin
               halt_pend_d = 1'b1;
            end
         end
         S_HALT: begin
            if (resume)
               state_d = S_FETCH;
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_BOOT;
         pend_valid_q  <= 1'b0;
         pend_trap_q   <= 1'b0;
         pend_target_q <= 32'h0;
         halt_pend_q   <= 1'b0;
         epc_q         <= 32'h0;
      end else begin
         state_q       <= state_d;
         pend_valid_q  <= pend_valid_d;
         pend_trap_q   <= pend_trap_d;
         pend_target_q <= pend_target_d;
         halt_pend_q   <= halt_pend_d;
         epc_q         <= epc_d;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenario bench for fetch_ctrl.
// Models the external PC register that loads PC_next every cycle.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc = 32'hDEAD_BEE0;
   logic [31:0] pc_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        instr_valid;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        trap;
   logic        halt;
   logic        resume;
   logic [31:0] epc;
   logic        misaligned_fault;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;

   fetch_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .PC              (pc),
      .PC_next         (pc_next),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .instr_valid     (instr_valid),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .trap            (trap),
      .halt            (halt),
      .resume          (resume),
      .epc             (epc),
      .misaligned_fault(misaligned_fault),
      .state           (state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) pc <= pc_next;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      imem_ready      = 1'b0;
      stall           = 1'b0;
      redirect        = 1'b0;
      redirect_target = 32'h0;
      trap            = 1'b0;
      halt            = 1'b0;
      resume          = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic run(input int n);
      imem_ready = 1'b1;
      repeat (n) tick();
      imem_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clear_inputs();
      imem_ready = 1'b1;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0) begin
         errors++; $display("FAIL rst_req got %b exp 0", imem_req);
      end
      checks++;
      if (pc_next !== 32'h0) begin
         errors++; $display("FAIL rst_pcnext got %h exp 0", pc_next);
      end
      checks++;
      if (state !== 2'b00 || epc !== 32'h0 || instr_valid !== 1'b0
          || misaligned_fault !== 1'b0) begin
         errors++;
         $display("FAIL rst_misc got st=%b epc=%h v=%b mf=%b exp 00/0/0/0",
                  state, epc, instr_valid, misaligned_fault);
      end
      tick();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (state !== 2'b00 || imem_req !== 1'b0) begin
         errors++; $display("FAIL boot_cycle got st=%b req=%b exp 00/0", state, imem_req);
      end
      tick();
   endtask

   task automatic test_seq();
      imem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (imem_addr !== 32'(4 * i) || instr_valid !== 1'b1 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL seq%0d got addr=%h v=%b req=%b exp %h/1/1",
                     i, imem_addr, instr_valid, imem_req, 32'(4 * i));
         end
         tick();
      end
      imem_ready = 1'b0;
   endtask

   task automatic test_wait();
      logic [31:0] ea;
      logic        ev;
      do_reset();
      for (int g = 0; g < 3; g++) begin
         ea = (g == 0) ? 32'h0 : 32'h4;
         for (int c = 0; c < 3; c++) begin
            imem_ready = (c == 2);
            stall      = (g == 1 && c == 2);
            ev         = (c == 2) && (g != 1);
            @(negedge clk);
            checks++;
            if (imem_addr !== ea || instr_valid !== ev) begin
               errors++;
               $display("FAIL wait g%0d c%0d got addr=%h v=%b exp %h/%b",
                        g, c, imem_addr, instr_valid, ea, ev);
            end
            tick();
         end
      end
      clear_inputs();
      @(negedge clk);
      checks++;
      if (imem_addr !== 32'h8) begin
         errors++; $display("FAIL wait_next got %h exp 8", imem_addr);
      end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      run(2);
      redirect = 1'b1;
      redirect_target = 32'h40;
      @(negedge clk);
      checks++;
      if (pc_next !== 32'h8 || instr_valid !== 1'b0) begin
         errors++; $display("FAIL rw_hold got pcn=%h v=%b exp 8/0", pc_next, instr_valid);
      end
      tick();
      redirect = 1'b0;
      tick();
      imem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (imem_addr !== 32'h8 || instr_valid !== 1'b0 || pc_next !== 32'h40) begin
         errors++;
         $display("FAIL rw_done got addr=%h v=%b pcn=%h exp 8/0/40",
                  imem_addr, instr_valid, pc_next);
      end
      tick();
      @(negedge clk);
      checks++;
      if (imem_addr !== 32'h40 || instr_valid !== 1'b1) begin
         errors++; $display("FAIL rw_target got addr=%h v=%b exp 40/1", imem_addr, instr_valid);
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_trap();
      do_reset();
      run(4);
      trap = 1'b1;
      redirect = 1'b1;
      redirect_target = 32'h40;
      @(negedge clk);
      checks++;
      if (pc_next !== 32'h10 || misaligned_fault !== 1'b0) begin
         errors++; $display("FAIL trap_hold got pcn=%h mf=%b exp 10/0", pc_next, misaligned_fault);
      end
      tick();
      trap = 1'b0;
      redirect_target = 32'h80;
      @(negedge clk);
      checks++;
      if (epc !== 32'h10) begin
         errors++; $display("FAIL trap_epc got %h exp 10", epc);
      end
      tick();
      redirect = 1'b0;
      imem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (pc_next !== 32'h100 || instr_valid !== 1'b0) begin
         errors++; $display("FAIL trap_done got pcn=%h v=%b exp 100/0", pc_next, instr_valid);
      end
      tick();
      @(negedge clk);
      checks++;
      if (imem_addr !== 32'h100) begin
         errors++; $display("FAIL trap_target got %h exp 100", imem_addr);
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_misaligned();
      do_reset();
      run(8);
      redirect = 1'b1;
      redirect_target = 32'h42;
      imem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (misaligned_fault !== 1'b1 || pc_next !== 32'h100 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL mis_evt got mf=%b pcn=%h v=%b exp 1/100/0",
                  misaligned_fault, pc_next, instr_valid);
      end
      tick();
      redirect = 1'b0;
      @(negedge clk);
      checks++;
      if (misaligned_fault !== 1'b0 || epc !== 32'h20 || imem_addr !== 32'h100) begin
         errors++;
         $display("FAIL mis_after got mf=%b epc=%h addr=%h exp 0/20/100",
                  misaligned_fault, epc, imem_addr);
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_wrap();
      do_reset();
      redirect = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      imem_ready = 1'b1;
      tick();
      redirect = 1'b0;
      @(negedge clk);
      checks++;
      if (imem_addr !== 32'hFFFF_FFFC || pc_next !== 32'h0 || instr_valid !== 1'b1) begin
         errors++;
         $display("FAIL wrap got addr=%h pcn=%h v=%b exp fffffffc/0/1",
                  imem_addr, pc_next, instr_valid);
      end
      tick();
      @(negedge clk);
      checks++;
      if (imem_addr !== 32'h0) begin
         errors++; $display("FAIL wrap_next got %h exp 0", imem_addr);
      end
      clear_inputs();
   endtask

   task automatic test_halt_resume_reset();
      do_reset();
      run(5);
      halt = 1'b1;
      @(negedge clk);
      checks++;
      if (pc_next !== 32'h14 || state !== 2'b01) begin
         errors++; $display("FAIL halt_req got pcn=%h st=%b exp 14/01", pc_next, state);
      end
      tick();
      halt = 1'b0;
      imem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || pc_next !== 32'h14) begin
         errors++; $display("FAIL halt_done got v=%b pcn=%h exp 0/14", instr_valid, pc_next);
      end
      tick();
      trap = 1'b1;
      redirect = 1'b1;
      redirect_target = 32'h40;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (state !== 2'b10 || imem_req !== 1'b0 || imem_addr !== 32'h14 || epc !== 32'h0) begin
         errors++;
         $display("FAIL halted got st=%b req=%b addr=%h epc=%h exp 10/0/14/0",
                  state, imem_req, imem_addr, epc);
      end
      clear_inputs();
      resume = 1'b1;
      tick();
      resume = 1'b0;
      imem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (state !== 2'b01 || imem_addr !== 32'h14 || instr_valid !== 1'b1) begin
         errors++;
         $display("FAIL resume got st=%b addr=%h v=%b exp 01/14/1",
                  state, imem_addr, instr_valid);
      end
      tick();
      imem_ready = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || pc_next !== 32'h0 || state !== 2'b00 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid got req=%b pcn=%h st=%b v=%b exp 0/0/00/0",
                  imem_req, pc_next, state, instr_valid);
      end
      tick();
      tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      checks++;
      if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
         errors++; $display("FAIL rst_refetch got addr=%h req=%b exp 0/1", imem_addr, imem_req);
      end
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      test_reset();
      test_seq();
      test_wait();
      test_redirect_wait();
      test_trap();
      test_misaligned();
      test_wrap();
      test_halt_resume_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end

endmodule
